lsu_requester: RTL and testbench
================================

LSU_REQUESTER -- requirements
Module: lsu_requester

Interface
REQ-001 Parameter DEPTH, default 2048, sets the data-memory depth in 32-bit words.
REQ-002 Parameter ADDR_WIDTH, default $clog2(DEPTH), sets the memory word-address width.
REQ-003 i_clk  input  1  clock; all state updates on the rising edge.
REQ-004 i_reset  input  1  reset; synchronous, active-high.
REQ-005 i_req  input  1  MEM-stage access request; accepted only in IDLE.
REQ-006 i_we  input  1  1 = store, 0 = load.
REQ-007 i_funct3  input  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 i_addr  input  32  byte address.
REQ-009 i_wdata  input  32  store data, right-justified.
REQ-010 o_busy  output  1  stall request to the pipeline.
REQ-011 o_done  output  1  single-cycle completion pulse.
REQ-012 o_rdata  output  32  aligned, sign- or zero-extended load result; valid while o_done is high.
REQ-013 o_err  output  1  access fault; valid while o_done is high.
REQ-014 o_mem_addr  output  ADDR_WIDTH  memory word address.
REQ-015 o_mem_wdata  output  32  lane-shifted store data.
REQ-016 o_mem_we  output  1  memory write enable.
REQ-017 o_mem_be  output  4  byte-lane enables, also used as read lane enables.
REQ-018 i_mem_rdata  input  32  memory read data, registered, one cycle after the address; disabled lanes read as zero.

Function
REQ-019 States: IDLE, LO, HI, DONE.
REQ-020 On acceptance (i_req in IDLE), the block registers i_we, i_funct3, i_addr and i_wdata; later input changes have no effect.
REQ-021 Decode: off = addr[1:0]; word = addr[ADDR_WIDTH+1:2]; size is 1, 2 or 4 bytes; be = size mask << off.
REQ-022 Aligned access (off + size <= 4):
- The memory ports are driven combinationally in the acceptance cycle, with o_mem_wdata = wdata << 8*off.
- Next state is DONE.
- o_done is asserted in cycle +1.
REQ-023 Misaligned access (off + size > 4), when the macro is defined:
- Acceptance cycle: lanes off..3 of word are accessed; next state is HI.
- HI: the remaining lanes of (word+1) mod DEPTH are accessed, with o_mem_wdata = wdata >> 8*(4-off); the low part is captured.
- DONE: the result is assembled and o_done is asserted in cycle +2.
REQ-024 Loads: the selected bytes are shifted down by 8*off and extended per funct3[2] (1 = zero-extend, 0 = sign-extend from the top accessed byte).
REQ-025 Stores: o_rdata is 0 at o_done.
REQ-026 o_busy is high in the acceptance cycle and in every state except IDLE and DONE, so the pipeline holds exactly until the o_done cycle.
REQ-027 i_req while not in IDLE is ignored. DONE returns to IDLE, and a new request is accepted in the following cycle.
REQ-028 Invalid funct3 (011, 110, 111, or any store with funct3[2]=1):
- No memory access; o_mem_we = 0 and o_mem_be = 0.
- Next state is DONE; o_done is asserted in cycle +1 with o_err = 1 and o_rdata = 0.
REQ-029 Outside active access cycles, o_mem_we = 0, o_mem_be = 0, and o_mem_addr holds its last value.
REQ-030 The word address wraps modulo DEPTH; wrap is not an error.

Reset
REQ-031 While i_reset is high: state = IDLE, o_busy = 0, o_done = 0, o_err = 0, o_rdata = 0, o_mem_we = 0, o_mem_be = 0, o_mem_addr = 0, o_mem_wdata = 0.
REQ-032 Reset during LO or HI abandons the access, and no memory write occurs in the reset cycle. The half-completed word of a split store stays written.

Configuration
REQ-033 Macro LSU_MISALIGN_EN defined: misaligned accesses are split as in REQ-023.
REQ-034 LSU_MISALIGN_EN undefined: a misaligned access performs no memory access and completes in cycle +1 with o_err = 1 and o_rdata = 0; the HI state is not compiled.

Structure
REQ-035 Package lsu_pkg holds:
- the state enum;
- the funct3 constants;
- a size enum (SZ_B, SZ_H, SZ_W);
- localparam WORD_BYTES = 4.
REQ-036 Sub-module lsu_align, purely combinational: extracts, shifts and extends load data from a 64-bit {hi, lo} window, the byte offset and funct3.

Verification
REQ-037 Word 4 = 0x8899AABB; LB at 0x13 -> o_rdata 0xFFFFFF88, o_done in cycle +1, o_err 0.
REQ-038 Word 4 = 0x8899AABB; LHU at 0x12 -> o_rdata 0x00008899; o_mem_be = 1100.
REQ-039 SH 0x0000BEEF at 0x22 -> o_mem_addr 8, o_mem_be 1100, o_mem_wdata 0xBEEF0000, o_mem_we high for one cycle.
REQ-040 Split load, LSU_MISALIGN_EN defined: word 4 = 0x8899AABB, word 5 = 0x11223344; LW at 0x12 -> o_rdata 0x33448899, o_done in cycle +2, o_busy high for 2 cycles. With the macro undefined: o_err 1 in cycle +1.
REQ-041 Split SW 0xDEADBEEF at 0x13, then i_reset asserted in the HI cycle -> word 4 lane 3 = 0xEF, word 5 unchanged, state IDLE, no o_done.
REQ-042 funct3 011 load -> no memory access; o_done with o_err 1 in cycle +1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store requester.
package lsu_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned widths exist only for loads.
  function automatic logic f3_valid(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [WORD_BYTES-1:0] size_mask(input logic [1:0] sz);
    logic [WORD_BYTES-1:0] m;
    case (sz)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Load data extraction: shifts a {hi, lo} read window down by the byte offset
// and sign- or zero-extends according to funct3.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] window,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    shifted = 32'(window >> {off, 3'b000});
    sext    = ~funct3[2];
    data    = '0;
    case (funct3[1:0])
      SZ_B:    data = {{24{sext & shifted[7]}}, shifted[7:0]};
      SZ_H:    data = {{16{sext & shifted[15]}}, shifted[15:0]};
      SZ_W:    data = shifted;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_requester.sv
// MEM-stage load/store requester for a registered-read word memory.
// Define LSU_MISALIGN_EN to split word-crossing accesses over two cycles.
module lsu_requester
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  input  logic [31:0]           i_mem_rdata
);

  state_e                state_q, state_d;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;

  logic [1:0]            req_off;
  logic [ADDR_WIDTH-1:0] req_word;
  logic [7:0]            req_be8;
  logic [31:0]           req_wdata_lo;
  logic                  req_split;
  logic                  req_ok;
  logic                  accept;
  logic [63:0]           align_window;
  logic [31:0]           align_data;
  logic                  unused_addr_bits;

`ifdef LSU_MISALIGN_EN
  logic                  split_q;
  logic [ADDR_WIDTH-1:0] hi_addr_q;
  logic [3:0]            hi_be_q;
  logic [31:0]           hi_wdata_q;
  logic [31:0]           lo_rdata_q;
  logic [ADDR_WIDTH-1:0] req_word_nxt;
  logic [31:0]           req_wdata_hi;
`endif

  // Request decode straight from the pipeline inputs (acceptance cycle only).
  assign req_off          = i_addr[1:0];
  assign req_word         = i_addr[ADDR_WIDTH+1:2];
  assign req_be8          = {4'b0000, size_mask(i_funct3[1:0])} << req_off;
  assign req_wdata_lo     = i_wdata << {req_off, 3'b000};
  assign req_split        = |req_be8[7:4];
  assign accept           = (state_q == ST_IDLE) && i_req;
  assign unused_addr_bits = ^i_addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_EN
  assign req_ok       = f3_valid(i_we, i_funct3);
  assign req_word_nxt = (req_word == ADDR_WIDTH'(DEPTH - 1)) ? '0 : req_word + ADDR_WIDTH'(1);
  assign req_wdata_hi = i_wdata >> (6'd32 - 6'({req_off, 3'b000}));
  assign align_window = split_q ? {i_mem_rdata, lo_rdata_q} : {32'h0, i_mem_rdata};
`else
  assign req_ok       = f3_valid(i_we, i_funct3) && !req_split;
  assign align_window = {32'h0, i_mem_rdata};
`endif

  lsu_align u_align (
    .window (align_window),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (align_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and all outputs; reset forces every output to zero last.
  always_comb begin
    state_d     = state_q;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_err       = 1'b0;
    o_rdata     = '0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = mem_addr_q;
    o_mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          o_busy  = 1'b1;
          state_d = ST_DONE;
          if (req_ok) begin
            o_mem_addr  = req_word;
            o_mem_be    = req_be8[3:0];
            o_mem_we    = i_we;
            o_mem_wdata = i_we ? req_wdata_lo : 32'h0;
`ifdef LSU_MISALIGN_EN
            if (req_split) state_d = ST_HI;
`endif
          end
        end
      end
`ifdef LSU_MISALIGN_EN
      ST_HI: begin
        o_busy      = 1'b1;
        o_mem_addr  = hi_addr_q;
        o_mem_be    = hi_be_q;
        o_mem_we    = we_q;
        o_mem_wdata = hi_wdata_q;
        state_d     = ST_DONE;
      end
`endif
      ST_DONE: begin
        o_done  = 1'b1;
        o_err   = err_q;
        o_rdata = (err_q || we_q) ? 32'h0 : align_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_reset) begin
      state_d     = ST_IDLE;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_err       = 1'b0;
      o_rdata     = '0;
      o_mem_we    = 1'b0;
      o_mem_be    = '0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
    end
  end

  // Request capture; o_mem_addr is remembered so it holds between accesses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
`ifdef LSU_MISALIGN_EN
      split_q    <= 1'b0;
      hi_addr_q  <= '0;
      hi_be_q    <= '0;
      hi_wdata_q <= '0;
      lo_rdata_q <= '0;
`endif
    end else begin
      mem_addr_q <= o_mem_addr;
      if (accept) begin
        we_q  <= i_we;
        f3_q  <= i_funct3;
        off_q <= req_off;
        err_q <= ~req_ok;
`ifdef LSU_MISALIGN_EN
        split_q    <= req_ok && req_split;
        hi_addr_q  <= req_word_nxt;
        hi_be_q    <= req_be8[7:4];
        hi_wdata_q <= req_wdata_hi;
`endif
      end
`ifdef LSU_MISALIGN_EN
      if (state_q == ST_HI) lo_rdata_q <= i_mem_rdata;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_requester.sv
// Bench for lsu_requester: byte-addressed reference model plus a registered-read
// word memory attached to the DUT memory port.
module tb_lsu_requester;

  localparam int DEPTH = 2048;
  localparam int AW    = 11;
  localparam int NBYTE = 4 * DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_we;
  logic [2:0]    i_funct3;
  logic [31:0]   i_addr, i_wdata;
  logic          o_busy, o_done, o_err, o_mem_we;
  logic [31:0]   o_rdata, o_mem_wdata;
  logic [AW-1:0] o_mem_addr;
  logic [3:0]    o_mem_be;
  logic [31:0]   mem_rdata_r;

  logic [31:0]   mem [DEPTH];
  logic [7:0]    bmem [NBYTE];
  logic          init_mem, bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_rdata, last_wdata0, last_addr0;
  logic        last_err;
  logic [3:0]  last_be0;
  int          last_lat, last_writes;

  always #5 clk = ~clk;

  lsu_requester #(.DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_we    (o_mem_we),
    .o_mem_be    (o_mem_be),
    .i_mem_rdata (mem_rdata_r)
  );

  function automatic logic [31:0] seed(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // Registered-read memory; disabled lanes read as zero.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= seed(w);
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (o_mem_we) begin
      for (int l = 0; l < 4; l++)
        if (o_mem_be[l]) mem[o_mem_addr][8*l +: 8] <= o_mem_wdata[8*l +: 8];
    end
    mem_rdata_r <= mem[o_mem_addr] & {{8{o_mem_be[3]}}, {8{o_mem_be[2]}},
                                      {8{o_mem_be[1]}}, {8{o_mem_be[0]}}};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int w, input logic [31:0] v);
    logic [31:0] t;
    @(negedge clk);
    bd_we = 1'b1; bd_addr = AW'(w); bd_data = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
    t = v;
    for (int b = 0; b < 4; b++) bmem[4*w + b] = t[8*b +: 8];
  endtask

  // One request through the DUT, checked against the byte-level model.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit noise);
    int sz, off, base, lat, nwr, cyc;
    bit valid, split, err, got_done;
    logic [31:0] exp_rd, wmask, exp_wd;
    logic [3:0]  exp_be;
    sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    valid = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || ((f3 == 3'd4 || f3 == 3'd5) && !we));
    off   = int'(addr[1:0]);
    base  = int'(addr % 32'(NBYTE));
    split = (off + sz) > 4;
`ifdef LSU_MISALIGN_EN
    err = !valid;
`else
    err = !valid || split;
`endif
    lat    = (split && !err) ? 2 : 1;
    exp_rd = '0;
    exp_be = '0;
    wmask  = '0;
    exp_wd = '0;
    if (!err) begin
      for (int i = 0; i < sz; i++)
        if (off + i < 4) begin
          exp_be[off + i]            = 1'b1;
          wmask[8*(off + i) +: 8]    = 8'hFF;
          exp_wd[8*(off + i) +: 8]   = wd[8*i +: 8];
        end
      if (!we) begin
        for (int i = 0; i < sz; i++) exp_rd[8*i +: 8] = bmem[(base + i) % NBYTE];
        if (!f3[2] && exp_rd[8*sz - 1])
          for (int i = sz; i < 4; i++) exp_rd[8*i +: 8] = 8'hFF;
      end else begin
        for (int i = 0; i < sz; i++) bmem[(base + i) % NBYTE] = wd[8*i +: 8];
      end
    end

    @(negedge clk);
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wd;
    #1;
    last_be0    = o_mem_be;
    last_addr0  = 32'(o_mem_addr);
    last_wdata0 = o_mem_wdata;
    check("busy_accept", 32'(o_busy), 32'd1);
    check("we_accept", 32'(o_mem_we), 32'(we && !err));
    check("be_accept", 32'(o_mem_be), 32'(exp_be));
    if (!err) check("addr_accept", 32'(o_mem_addr), 32'(base / 4));
    if (!err && we) check("wdata_accept", o_mem_wdata & wmask, exp_wd);
    nwr = o_mem_we ? 1 : 0;

    @(posedge clk); #1;
    i_req = noise; i_we = 1'($urandom); i_funct3 = 3'($urandom);
    i_addr = $urandom; i_wdata = $urandom;

    cyc = 1; got_done = 0; last_lat = 0; last_rdata = 'x; last_err = 1'bx;
    while (!got_done && cyc <= 4) begin
      @(negedge clk);
      if (o_mem_we) nwr++;
      check("done_timing", 32'(o_done), 32'(cyc == lat));
      check("busy_timing", 32'(o_busy), 32'(cyc < lat));
      if (o_done) begin
        got_done   = 1;
        last_lat   = cyc;
        last_rdata = o_rdata;
        last_err   = o_err;
      end
      cyc++;
    end
    last_writes = nwr;
    check("done_seen", 32'(got_done), 32'd1);
    check("rdata", last_rdata, exp_rd);
    check("err", 32'(last_err), 32'(err));
    check("latency", 32'(last_lat), 32'(lat));
    check("write_count", 32'(nwr), (we && !err) ? (split ? 32'd2 : 32'd1) : 32'd0);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    rst = 1'b1; init_mem = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h10; i_wdata = 32'hFFFF_FFFF;
    for (int w = 0; w < DEPTH; w++) begin
      t = seed(w);
      for (int b = 0; b < 4; b++) bmem[4*w + b] = t[8*b +: 8];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_mem_we", 32'(o_mem_we), 32'd0);
    check("rst_mem_be", 32'(o_mem_be), 32'd0);
    check("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    check("rst_mem_wdata", o_mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; init_mem = 1'b0; i_req = 1'b0;

    // Directed cases from the requirement examples.
    poke(4, 32'h8899AABB);
    poke(5, 32'h11223344);
    do_op(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    check("lb_value", last_rdata, 32'hFFFFFF88);
    check("lb_latency", 32'(last_lat), 32'd1);
    do_op(1'b0, 3'b101, 32'h12, 32'h0, 1'b0);
    check("lhu_value", last_rdata, 32'h00008899);
    check("lhu_be", 32'(last_be0), 32'b1100);
    do_op(1'b1, 3'b001, 32'h22, 32'h0000BEEF, 1'b0);
    check("sh_addr", last_addr0, 32'd8);
    check("sh_be", 32'(last_be0), 32'b1100);
    check("sh_wdata", last_wdata0, 32'hBEEF0000);
    check("sh_writes", 32'(last_writes), 32'd1);
    check("sh_word8", mem[8][31:16], 32'h0000BEEF);
    do_op(1'b0, 3'b010, 32'h12, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_EN
    check("split_lw_value", last_rdata, 32'h33448899);
    check("split_lw_latency", 32'(last_lat), 32'd2);
`else
    check("split_lw_err", 32'(last_err), 32'd1);
    check("split_lw_latency", 32'(last_lat), 32'd1);
`endif
    do_op(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
    check("f3_011_err", 32'(last_err), 32'd1);
    do_op(1'b1, 3'b100, 32'h10, 32'h12345678, 1'b0);
    do_op(1'b0, 3'b110, 32'h10, 32'h0, 1'b1);
    // Word-address wrap at the top of memory.
    do_op(1'b1, 3'b010, 32'h1FFE, 32'hCAFEF00D, 1'b0);
    do_op(1'b0, 3'b010, 32'h1FFE, 32'h0, 1'b0);
    do_op(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_op(1'b0, 3'b010, 32'h0, 32'h0, 1'b0);

    // Reset in the second half of a split store.
    poke(4, 32'h8899AABB);
    poke(5, 32'h11223344);
    @(negedge clk);
    i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h13; i_wdata = 32'hDEADBEEF;
    #1 check("rst_split_busy", 32'(o_busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; i_req = 1'b0;
    @(negedge clk);
    check("rst_hi_mem_we", 32'(o_mem_we), 32'd0);
    check("rst_hi_mem_be", 32'(o_mem_be), 32'd0);
    check("rst_hi_busy", 32'(o_busy), 32'd0);
    check("rst_hi_done", 32'(o_done), 32'd0);
    check("rst_hi_addr", 32'(o_mem_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", 32'(o_done), 32'd0);
    check("post_rst_busy", 32'(o_busy), 32'd0);
`ifdef LSU_MISALIGN_EN
    check("rst_word4", mem[4], 32'hEF99AABB);
    bmem[16 + 3] = 8'hEF;
`else
    check("rst_word4", mem[4], 32'h8899AABB);
`endif
    check("rst_word5", mem[5], 32'h11223344);
    do_op(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    do_op(1'b0, 3'b010, 32'h14, 32'h0, 1'b0);

    // Randomized mix; small address window so loads see earlier stores.
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h1FC0 + 32'($urandom_range(0, 95));
      else             a = 32'($urandom_range(0, 95));
      do_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
            1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
